// File: rtl/seg_capture.sv
// Seven-segment display sniffer: synchronizes a multiplexed an/seg/dp bus,
// waits for each digit to settle, decodes it and reports per-position hex values.
module seg_capture_pos (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap,
  input  logic       hit,
  input  logic [3:0] val,
  input  logic       dp_lit,
  output logic [3:0] digit,
  output logic       valid,
  output logic       dp_seen
);
  // Blank and undecodable patterns both invalidate the position but keep its value.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      digit   <= '0;
      valid   <= 1'b0;
      dp_seen <= 1'b0;
    end else if (cap) begin
      valid <= hit;
      if (hit) begin
        digit   <= val;
        dp_seen <= dp_lit;
      end
    end
endmodule

module seg_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] digit_valid,
  output logic [3:0] dp_seen,
  output logic       frame_valid,
  output logic       err_pattern,
  output logic       err_multi_an,
  output logic       stale
);
  localparam int NUM_LANES = 4;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                         state, state_n;
  logic [6:0]                     seg_s1, seg_q, seg_prev;
  logic [3:0]                     an_s1, an_q, an_prev;
  logic                           dp_s1, dp_q, dp_prev;
  logic [SW-1:0]                  cnt, cnt_n;
  logic [3:0]                     sel, sel_n;
  logic                           ack, ack_n;
  logic [NUM_LANES-1:0]           mask;
  logic [TW-1:0]                  idle_cnt;
  logic                           cap_en, one_hot, hit, blank;
  logic [3:0]                     val;
  logic [3:0]                     an_low;
  logic [NUM_LANES-1:0][3:0]      digit_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg_s1 <= '1; seg_q <= '1; seg_prev <= '1;
      an_s1  <= '1; an_q  <= '1; an_prev  <= '1;
      dp_s1  <= 1'b1; dp_q <= 1'b1; dp_prev <= 1'b1;
    end else begin
      seg_s1 <= seg; seg_q <= seg_s1; seg_prev <= seg_q;
      an_s1  <= an;  an_q  <= an_s1;  an_prev  <= an_q;
      dp_s1  <= dp;  dp_q  <= dp_s1;  dp_prev  <= dp_q;
    end

  assign an_low  = ~an_q;
  assign one_hot = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);

  // CAPTURE decodes the previous-cycle seg/dp: the values that held through settling.
  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    val   = 4'h0;
    case (seg_prev)
      7'h40: val = 4'h0;  7'h79: val = 4'h1;  7'h24: val = 4'h2;  7'h30: val = 4'h3;
      7'h19: val = 4'h4;  7'h12: val = 4'h5;  7'h02: val = 4'h6;  7'h78: val = 4'h7;
      7'h00: val = 4'h8;  7'h10: val = 4'h9;  7'h08: val = 4'hA;  7'h03: val = 4'hB;
      7'h46: val = 4'hC;  7'h21: val = 4'hD;  7'h06: val = 4'hE;  7'h0E: val = 4'hF;
      7'h7F: begin hit = 1'b0; blank = 1'b1; end
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    ack_n        = ack;
    err_multi_an = 1'b0;
    cap_en       = 1'b0;
    if (an_q != an_prev) ack_n = 1'b0;
    case (state)
      IDLE:
        if (one_hot) begin
          state_n = SETTLE; cnt_n = '0; sel_n = an_q;
        end else if (an_q != 4'hF && (!ack || an_q != an_prev)) begin
          err_multi_an = 1'b1; ack_n = 1'b1;
        end
      SETTLE:
        if (an_q != sel || seg_q != seg_prev) begin
          if (one_hot) begin cnt_n = '0; sel_n = an_q; end
          else state_n = IDLE;
        end else if (cnt == SW'(SETTLE_CYCLES - 1)) state_n = CAPTURE;
        else cnt_n = cnt + SW'(1);
      CAPTURE: begin
        cap_en  = 1'b1;
        state_n = HOLD;
      end
      HOLD:
        if (an_q != sel) begin
          if (one_hot) begin state_n = SETTLE; cnt_n = '0; sel_n = an_q; end
          else state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 4'hF;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      ack   <= ack_n;
    end

  // Frame completes one cycle after the mask fills; the mask restarts in that cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask        <= '0;
      frame_valid <= 1'b0;
    end else if (mask == 4'hF) begin
      mask        <= '0;
      frame_valid <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
      if (cap_en) mask <= mask | ~sel;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)                                  idle_cnt <= '0;
    else if (cap_en)                          idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + TW'(1);

  assign stale       = (idle_cnt == TW'(TIMEOUT_CYCLES));
  assign err_pattern = cap_en & ~hit & ~blank;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_pos
    seg_capture_pos u_pos (
      .clk     (clk),
      .rst     (rst),
      .cap     (cap_en & ~sel[i]),
      .hit     (hit),
      .val     (val),
      .dp_lit  (~dp_prev),
      .digit   (digit_q[i]),
      .valid   (digit_valid[i]),
      .dp_seen (dp_seen[i])
    );
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: synced cycles an/seg must hold steady before a digit is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000: cycles without a capture before stale asserts.
REQ-003 SHALL have one clock and asynchronous active-high reset, ports in this order:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous active-high reset
- seg  input  7  cathodes, active low, seg[0]=a … seg[6]=g
- dp  input  1  decimal point, active low
- an  input  4  anode enables, active low, an[3]=digit3 … an[0]=digit0
- digit3, digit2, digit1, digit0  output  4 each  last decoded hex value per position
- digit_valid  output  4  bit n=1: position n decoded in current frame
- dp_seen  output  4  bit n: dp state (1=lit) at last capture of position n
- frame_valid  output  1  one-cycle pulse, all four positions captured
- err_pattern  output  1  one-cycle pulse, undecodable segment pattern
- err_multi_an  output  1  one-cycle pulse, more than one anode low
- stale  output  1  level, no capture for TIMEOUT_CYCLES

Function
REQ-004 SHALL pass seg, dp, an through two-flop synchronizers; all timing below counts from synchronized values.
REQ-005 SHALL run FSM IDLE, SETTLE, CAPTURE, HOLD.
REQ-006 IDLE: an==4'b1111 stays IDLE; exactly one an bit low -> SETTLE, settle counter cleared; two or more low -> err_multi_an pulse once, remain IDLE until an changes.
REQ-007 SETTLE: counter increments per cycle; any change of an or seg restarts counter (new one-hot an stays SETTLE, non-one-hot an -> IDLE per REQ-006); counter reaching SETTLE_CYCLES-1 -> CAPTURE.
REQ-008 CAPTURE: one cycle; decodes seg per REQ-009, updates selected position, then -> HOLD.
REQ-009 decode table, seg as {g..a} hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-010 matched pattern: digitN <= value, digit_valid[N] <= 1, capture mask bit N <= 1, dp_seen[N] <= ~dp.
REQ-011 blank 7F: digitN unchanged, digit_valid[N] <= 0, mask bit N <= 1, no error.
REQ-012 other pattern: err_pattern pulse in CAPTURE cycle, digitN unchanged, digit_valid[N] <= 0, mask bit N <= 1.
REQ-013 HOLD: remain while an unchanged; on any an change -> SETTLE if one-hot, else IDLE (err_multi_an per REQ-006).
REQ-014 recapture of an already-masked position overwrites its outputs; mask unchanged.
REQ-015 when mask becomes 4'b1111 SHALL pulse frame_valid the next cycle and clear mask that same cycle; digit_valid then clears only on per-position recapture rules.
REQ-016 idle counter SHALL increment every non-CAPTURE cycle, saturate at TIMEOUT_CYCLES, clear on CAPTURE; stale=1 while counter==TIMEOUT_CYCLES; width $clog2(TIMEOUT_CYCLES+1).
REQ-017 SHALL never sample a position whose an went high before settling completed.

Reset
REQ-018 rst SHALL asynchronously force: state IDLE, synchronizers to 1 (inactive), counters 0, mask 0, digit3..digit0=0, digit_valid=0, dp_seen=0, frame_valid=0, err_pattern=0, err_multi_an=0, stale=0.
REQ-019 rst asserted mid-SETTLE or mid-CAPTURE SHALL discard the pending capture; first capture after release requires full SETTLE_CYCLES.

Verification
REQ-020 scan an 1110,1101,1011,0111 with seg 40,79,24,30, 1000 cycles each -> digit0..3=0,1,2,3, digit_valid=1111, exactly one frame_valid per four-digit scan.
REQ-021 an=1110, seg toggles every 2 cycles (SETTLE_CYCLES=4) -> no capture, digit0 unchanged; seg then steady -> capture 4+2 sync cycles after last change.
REQ-022 an=1100 -> single err_multi_an pulse, no capture, state IDLE; an=1110 then -> normal capture.
REQ-023 seg=7E on digit2 -> err_pattern pulse, digit_valid[2]=0, digit2 unchanged; seg=7F -> no error, digit_valid[2]=0.
REQ-024 TIMEOUT_CYCLES=100, an held 1111 -> stale=1 at cycle 100, cleared on next capture; dp=0 with seg=00 on digit1 -> digit1=8, dp_seen[1]=1.
REQ-025 rst pulse during SETTLE of digit3 -> all outputs zero immediately, no frame_valid until four fresh captures.
